// File: rtl/unified_mem_sequencer.sv
// Arbitrates one single-ported unified memory between instruction fetch and the
// load/store stage. Each step runs an optional data access, a fetch, then one advance cycle.
module unified_mem_sequencer #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] PCF,
   input  logic          MemtoRegM,
   input  logic          MemWriteM,
   input  logic [AW-1:0] ALUOutM,
   input  logic [DW-1:0] WriteDataM,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [DW-1:0] InstrF,
   output logic [DW-1:0] ReadDataM,
   output logic          Stall,
   output logic          MemErr,
   output logic [31:0]   StallCnt
);

   typedef enum logic [1:0] {S_DATA, S_FETCH, S_ADV} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q;
   logic          req_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] instr_q;
   logic [DW-1:0] rdata_q;
   logic          stall_q;
   logic          err_q;
   logic [31:0]   scnt_q;
   logic [7:0]    wait_q;

   logic          op_d;
   logic          done_d;
   logic          expire_d;
   logic [7:0]    wait_d;

   always_comb begin
      op_d     = MemtoRegM | MemWriteM;
      done_d   = req_q & mem_ready;
      expire_d = req_q & ~mem_ready & (wait_q == WAIT_LAST);
      wait_d   = wait_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_DATA;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         instr_q <= '0;
         rdata_q <= '0;
         stall_q <= 1'b1;
         err_q   <= 1'b0;
         scnt_q  <= '0;
         wait_q  <= '0;
      end else begin
         if (stall_q) scnt_q <= scnt_q + 32'd1;
         case (state_q)
            S_DATA: begin
               if (!req_q) begin
                  // No request was pre-issued on entry (e.g. just out of reset):
                  // a pending MEM op is started now, otherwise go straight to fetch.
                  if (op_d) begin
                     req_q   <= 1'b1;
                     we_q    <= MemWriteM;
                     addr_q  <= ALUOutM;
                     wdata_q <= WriteDataM;
                     wait_q  <= '0;
                  end else begin
                     state_q <= S_FETCH;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= PCF;
                     wait_q  <= '0;
                  end
               end else if (done_d || expire_d) begin
                  if (done_d && !we_q) rdata_q <= mem_rdata;
                  if (expire_d) err_q <= 1'b1;
                  state_q <= S_FETCH;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= PCF;
                  wait_q  <= '0;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_FETCH: begin
               if (done_d || expire_d) begin
                  if (done_d) instr_q <= mem_rdata;
                  if (expire_d) err_q <= 1'b1;
                  state_q <= S_ADV;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  stall_q <= 1'b0;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_ADV: begin
               // Controls seen here belong to the instruction entering MEM, so the
               // data request goes out on the very first cycle of S_DATA.
               state_q <= S_DATA;
               stall_q <= 1'b1;
               req_q   <= op_d;
               we_q    <= MemWriteM;
               addr_q  <= ALUOutM;
               wdata_q <= WriteDataM;
               wait_q  <= '0;
            end
            default: begin
               state_q <= S_DATA;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               stall_q <= 1'b1;
            end
         endcase
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign InstrF    = instr_q;
   assign ReadDataM = rdata_q;
   assign Stall     = stall_q;
   assign MemErr    = err_q;
   assign StallCnt  = scnt_q;

endmodule

// File: doc/unified_mem_sequencer.md
Name: unified_mem_sequencer

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and the load/store stage (MEM) of the pipelined core.
- Sequences each pipeline step as: optional data access, then instruction fetch, then one advance cycle.
- Drives a global stall to all pipeline latches while memory work for the step is outstanding, and holds fetched instruction and load data stable for the advance cycle.

Parameters:
- AW, 32, memory address width.
- DW, 32, memory data width.
- TIMEOUT, 255, maximum wait cycles for mem_ready before aborting an access (8-bit counter).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- PCF  in  AW  fetch address from the IF stage.
- MemtoRegM  in  1  MEM-stage load request.
- MemWriteM  in  1  MEM-stage store request.
- ALUOutM  in  AW  MEM-stage data address.
- WriteDataM  in  DW  MEM-stage store data.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  AW  access address.
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  read data, valid when mem_ready=1.
- mem_ready  in  1  access-complete strobe, sampled while mem_req=1.
- InstrF  out  DW  fetched instruction (holding register).
- ReadDataM  out  DW  load result (holding register).
- Stall  out  1  global pipeline stall (1 = hold all latches).
- MemErr  out  1  sticky timeout flag.
- StallCnt  out  32  count of cycles with Stall=1, wraps modulo 2^32.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=S_DATA; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - InstrF=0, ReadDataM=0, Stall=1, MemErr=0, StallCnt=0, wait counter=0.
  - An in-flight access is abandoned; the memory must tolerate mem_req dropping.
- All outputs are registered. Stall=1 in S_DATA and S_FETCH; Stall=0 only in S_ADV.
- S_DATA:
  - If MemtoRegM=0 and MemWriteM=0: no request; next state is S_FETCH.
  - Otherwise: mem_req=1, mem_we=MemWriteM, mem_addr=ALUOutM, mem_wdata=WriteDataM. Address, data and we are held stable until completion.
  - If MemtoRegM=1 and MemWriteM=1 together: treat as a store (mem_we=1) and leave ReadDataM unchanged.
  - On the clk edge where mem_req=1 and mem_ready=1: if it was a load, ReadDataM<=mem_rdata. Next state is S_FETCH.
- S_FETCH: mem_req=1, mem_we=0, mem_addr=PCF. On mem_ready=1: InstrF<=mem_rdata; next state is S_ADV.
- S_ADV:
  - mem_req=0 and Stall=0 for exactly one cycle. Pipeline latches capture InstrF and ReadDataM.
  - Next state is S_DATA, which re-samples the MEM-stage controls of the newly advanced instruction.
- Handshake:
  - mem_req is raised on the cycle the state is entered.
  - A mem_ready that is already high completes the access on the first edge.
  - mem_ready while mem_req=0 is ignored.
  - At most one access is outstanding.
- Step latency with zero wait states is exactly 3 cycles, with or without a data access. Each wait cycle adds 1.
- Timeout:
  - The wait counter clears on entering S_DATA or S_FETCH and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT: MemErr<=1 (sticky until reset), abort the access (mem_req<=0), leave the destination register unchanged, and proceed to the next state as if the access had completed.
- StallCnt increments on every edge where Stall=1, including after reset release. It is not reset by MemErr.

Test Plan:
- Reset: drive reset=0 mid-S_FETCH with mem_req=1 -> mem_req=0, Stall=1, InstrF=0, StallCnt=0 immediately, without waiting for a clock edge; after release, first mem_req is a fetch of PCF=0x0 one cycle later (no MEM op).
- No-wait fetch only: mem_ready tied 1, PCF=0x40, mem_rdata=0x8C020004 -> Stall low 1 of every 3 cycles; InstrF=0x8C020004 during S_ADV; StallCnt=2 after first step.
- Load with 2 wait states: MemtoRegM=1, ALUOutM=0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0 held 3 cycles; ReadDataM=0xDEADBEEF; then fetch; step length 5 cycles.
- Store: MemWriteM=1, ALUOutM=0x104, WriteDataM=0x12345678 -> mem_we=1, mem_wdata=0x12345678 until ready; ReadDataM unchanged; followed by fetch with mem_we=0.
- Timeout: TIMEOUT=4, mem_ready=0 during fetch -> mem_req drops after 4 wait cycles; MemErr=1 and stays 1; InstrF keeps its previous value; S_ADV occurs.
- Simultaneous load+store flags and mem_ready asserted while idle -> access performed as a store; the idle ready pulse causes no state change.
